board_move_finder: RTL and testbench

Parametrised occupancy tracker and free-cell search engine for the N-cell game board used by the VGA game logic. It records which player (PL = human, PC = computer) owns each cell and enforces first-writer-wins on every cell. On request, it scans the board from a rotating start offset and returns a free cell for the computer's move, or reports that the board is full. It sits between the player/PC input decoders and the VGA renderer, which reads `cell_state` directly.

---
 rtl/board_pkg.sv | 21 ++
 rtl/board_cell.sv | 36 +++
 rtl/board_move_finder.sv | 141 ++++++++++++++
 tb/tb_board_move_finder.sv | 267 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/board_pkg.sv
// Shared types for the board occupancy tracker: cell owner encoding and
// the free-cell search FSM states.
package board_pkg;

  localparam logic [1:0] ENC_EMPTY = 2'b00;
  localparam logic [1:0] ENC_PL    = 2'b01;
  localparam logic [1:0] ENC_PC    = 2'b10;

  typedef enum logic [1:0] {
    EMPTY = ENC_EMPTY,
    PL    = ENC_PL,
    PC    = ENC_PC
  } cell_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SCAN = 2'd1,
    RESP = 2'd2
  } find_state_t;

endpackage

// File: rtl/board_cell.sv
// One board cell: owner register with first-writer-wins, PC priority on a
// simultaneous write, and per-cycle newly_set / conflict strobes.
module board_cell
  import board_pkg::*;
(
  input  logic  clock,
  input  logic  reset,
  input  logic  clear,
  input  logic  pl_en,
  input  logic  pc_en,
  output cell_t state,
  output logic  newly_set,
  output logic  conflict
);

  logic is_empty;
  logic any_en;
  logic wipe;

  assign is_empty = (state == EMPTY);
  assign any_en   = pl_en | pc_en;
  assign wipe     = reset | clear;

  // enables during a wipe are dropped entirely, so they raise no strobes
  assign newly_set = !wipe && is_empty && any_en;
  assign conflict  = !wipe && any_en && (!is_empty || (pl_en && pc_en));

  always_ff @(posedge clock) begin
    if (wipe) begin
      state <= EMPTY;
    end else if (newly_set) begin
      state <= pc_en ? PC : PL;
    end
  end

endmodule

// File: rtl/board_move_finder.sv
// Board occupancy tracker plus a rotating-start free-cell search used to
// pick the computer's move.
//
// state | meaning
// IDLE  | waiting for req; latches start offset on req
// SCAN  | examines one cell per cycle from the start offset, wrapping
// RESP  | resp_valid held with stable pos/full until resp_ready
module board_move_finder
  import board_pkg::*;
#(
  parameter int CELLS = 9,
  parameter int IDX_W = $clog2(CELLS),
  parameter int CNT_W = $clog2(CELLS + 1)
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               clear,
  input  logic [CELLS-1:0]   pl_en,
  input  logic [CELLS-1:0]   pc_en,
  input  logic               req,
  input  logic               resp_ready,
  output logic               busy,
  output logic               resp_valid,
  output logic               resp_full,
  output logic [IDX_W-1:0]   resp_pos,
  output logic [2*CELLS-1:0] cell_state,
  output logic [CNT_W-1:0]   occ_count,
  output logic               board_full,
  output logic               wr_conflict
);

  localparam logic [1:0] ST_IDLE = IDLE;
  localparam logic [1:0] ST_SCAN = SCAN;
  localparam logic [1:0] ST_RESP = RESP;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(CELLS - 1);

  function automatic logic [IDX_W-1:0] next_idx(input logic [IDX_W-1:0] cur);
    return (cur == LAST_IDX) ? '0 : cur + IDX_W'(1);
  endfunction

  cell_t            cell_q [CELLS];
  logic [CELLS-1:0] newly_set;
  logic [CELLS-1:0] conflict;
  logic [CNT_W-1:0] set_cnt;

  logic [1:0]       state;
  logic [IDX_W-1:0] start_ctr;
  logic [IDX_W-1:0] idx;
  logic [IDX_W-1:0] scanned;

  for (genvar i = 0; i < CELLS; i++) begin : g_cell
    board_cell u_cell (
      .clock     (clock),
      .reset     (reset),
      .clear     (clear),
      .pl_en     (pl_en[i]),
      .pc_en     (pc_en[i]),
      .state     (cell_q[i]),
      .newly_set (newly_set[i]),
      .conflict  (conflict[i])
    );
    assign cell_state[2*i +: 2] = cell_q[i];
  end

  always_comb begin
    set_cnt = '0;
    for (int i = 0; i < CELLS; i++) begin
      set_cnt = set_cnt + CNT_W'(newly_set[i]);
    end
  end

  // newly_set only fires on EMPTY cells, so the count cannot pass CELLS
  always_ff @(posedge clock) begin
    if (reset || clear) begin
      occ_count <= '0;
    end else begin
      occ_count <= occ_count + set_cnt;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      wr_conflict <= 1'b0;
    end else begin
      wr_conflict <= |conflict;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      start_ctr <= '0;
    end else begin
      start_ctr <= next_idx(start_ctr);
    end
  end

  always_ff @(posedge clock) begin
    if (reset || clear) begin
      state     <= ST_IDLE;
      idx       <= '0;
      scanned   <= '0;
      resp_pos  <= '0;
      resp_full <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (req) begin
            idx     <= start_ctr;
            scanned <= '0;
            state   <= ST_SCAN;
          end
        end
        ST_SCAN: begin
          if (cell_q[idx] == EMPTY) begin
            resp_pos  <= idx;
            resp_full <= 1'b0;
            state     <= ST_RESP;
          end else begin
            idx     <= next_idx(idx);
            scanned <= scanned + IDX_W'(1);
            if (scanned == LAST_IDX) begin
              resp_full <= 1'b1;
              state     <= ST_RESP;
            end
          end
        end
        ST_RESP: begin
          if (resp_ready) begin
            state <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign busy       = (state != ST_IDLE);
  assign resp_valid = (state == ST_RESP);
  assign board_full = (occ_count == CNT_W'(CELLS));

endmodule

// File: tb/tb_board_move_finder.sv
// Self-checking bench for board_move_finder: directed scenarios with literal
// expectations plus randomized traffic checked every cycle against a model.
module tb_board_move_finder;

  localparam int CELLS = 9;
  localparam int IDX_W = $clog2(CELLS);
  localparam int CNT_W = $clog2(CELLS + 1);

  logic               clock = 1'b0;
  logic               reset;
  logic               clear;
  logic [CELLS-1:0]   pl_en;
  logic [CELLS-1:0]   pc_en;
  logic               req;
  logic               resp_ready;
  logic               busy;
  logic               resp_valid;
  logic               resp_full;
  logic [IDX_W-1:0]   resp_pos;
  logic [2*CELLS-1:0] cell_state;
  logic [CNT_W-1:0]   occ_count;
  logic               board_full;
  logic               wr_conflict;

  int checks = 0;
  int errors = 0;

  board_move_finder #(.CELLS(CELLS)) dut (
    .clock       (clock),
    .reset       (reset),
    .clear       (clear),
    .pl_en       (pl_en),
    .pc_en       (pc_en),
    .req         (req),
    .resp_ready  (resp_ready),
    .busy        (busy),
    .resp_valid  (resp_valid),
    .resp_full   (resp_full),
    .resp_pos    (resp_pos),
    .cell_state  (cell_state),
    .occ_count   (occ_count),
    .board_full  (board_full),
    .wr_conflict (wr_conflict)
  );

  always #5 clock = ~clock;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model. Mode: 0 idle, 1 searching, 2 response pending.
  int m_cells [CELLS];
  int m_cnt, m_conf, m_start, m_mode, m_t, m_s, m_pos, m_full, m_cyc;
  bit model_ok = 0;

  always @(posedge clock) begin
    if (reset) begin
      for (int i = 0; i < CELLS; i++) m_cells[i] = 0;
      m_cnt = 0; m_conf = 0; m_start = 0; m_mode = 0;
      m_pos = 0; m_full = 0;
      model_ok = 1;
    end else begin
      if (clear) begin
        for (int i = 0; i < CELLS; i++) m_cells[i] = 0;
        m_cnt = 0; m_conf = 0; m_mode = 0;
      end else begin
        // search uses the cell contents before this edge's writes
        if (m_mode == 0) begin
          if (req) begin m_mode = 1; m_t = m_cyc; m_s = m_start; end
        end else if (m_mode == 1) begin
          int k, p;
          k = m_cyc - m_t - 1;
          p = (m_s + k) % CELLS;
          if (m_cells[p] == 0) begin
            m_mode = 2; m_pos = p; m_full = 0;
          end else if (k == CELLS - 1) begin
            m_mode = 2; m_full = 1;
          end
        end else begin
          if (resp_ready) m_mode = 0;
        end
        m_conf = 0;
        for (int i = 0; i < CELLS; i++) begin
          if (pl_en[i] || pc_en[i]) begin
            if (m_cells[i] != 0) m_conf = 1;
            else begin
              m_cells[i] = pc_en[i] ? 2 : 1;
              m_cnt++;
            end
            if (pl_en[i] && pc_en[i]) m_conf = 1;
          end
        end
      end
      m_start = (m_start + 1) % CELLS;
    end
    m_cyc++;
  end

  always @(negedge clock) begin
    if (model_ok) begin
      logic [2*CELLS-1:0] exp_state;
      for (int i = 0; i < CELLS; i++) exp_state[2*i +: 2] = 2'(m_cells[i]);
      chk("cell_state", int'(cell_state), int'(exp_state));
      chk("occ_count", int'(occ_count), m_cnt);
      chk("board_full", int'(board_full), int'(m_cnt == CELLS));
      chk("wr_conflict", int'(wr_conflict), m_conf);
      chk("busy", int'(busy), int'(m_mode != 0));
      chk("resp_valid", int'(resp_valid), int'(m_mode == 2));
      if (m_mode == 2) begin
        chk("resp_full", int'(resp_full), m_full);
        if (m_full == 0) chk("resp_pos", int'(resp_pos), m_pos);
      end
    end
  end

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic idle_inputs();
    clear = 0; pl_en = '0; pc_en = '0; req = 0; resp_ready = 0;
  endtask

  task automatic wait_start(input int v);
    int n = 0;
    while (m_start != v && n < 2 * CELLS) begin step(); n++; end
    chk("wait_start_bound", m_start, v);
  endtask

  task automatic handshake();
    resp_ready = 1; step(); resp_ready = 0;
    chk("busy_after_hs", int'(busy), 0);
    chk("valid_after_hs", int'(resp_valid), 0);
  endtask

  initial begin
    logic [CELLS-1:0] one;
    int held_pos;
    one = CELLS'(1);
    idle_inputs();
    reset = 1;
    step(); step();
    reset = 0;

    chk("rst_cells", int'(cell_state), 0);
    chk("rst_occ", int'(occ_count), 0);
    chk("rst_full", int'(board_full), 0);
    chk("rst_conf", int'(wr_conflict), 0);
    chk("rst_valid", int'(resp_valid), 0);
    chk("rst_rfull", int'(resp_full), 0);
    chk("rst_pos", int'(resp_pos), 0);
    chk("rst_busy", int'(busy), 0);

    // empty board, start offset 4
    wait_start(4);
    req = 1; step(); req = 0;
    chk("t1_busy", int'(busy), 1);
    chk("t1_valid_early", int'(resp_valid), 0);
    step();
    chk("t1_valid", int'(resp_valid), 1);
    chk("t1_pos", int'(resp_pos), 4);
    chk("t1_rfull", int'(resp_full), 0);
    handshake();

    // cells 4..8 taken by PL, start 6 wraps to 0
    pl_en = 9'h1F0; step(); pl_en = '0;
    chk("t2_occ", int'(occ_count), 5);
    chk("t2_conf", int'(wr_conflict), 0);
    wait_start(6);
    req = 1; step(); req = 0;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("t2_valid_early", int'(resp_valid), 0);
    end
    step();
    chk("t2_valid", int'(resp_valid), 1);
    chk("t2_pos", int'(resp_pos), 0);
    handshake();

    // full board
    pc_en = 9'h00F; step(); pc_en = '0;
    chk("t3_occ", int'(occ_count), 9);
    chk("t3_bfull", int'(board_full), 1);
    req = 1; step(); req = 0;
    for (int i = 0; i < 8; i++) begin
      step();
      chk("t3_valid_early", int'(resp_valid), 0);
    end
    step();
    chk("t3_valid", int'(resp_valid), 1);
    chk("t3_rfull", int'(resp_full), 1);
    handshake();

    // simultaneous PL/PC write, then a late PL write
    clear = 1; step(); clear = 0;
    chk("t4_clear_occ", int'(occ_count), 0);
    pc_en = 9'h010; pl_en = 9'h010; step(); pc_en = '0; pl_en = '0;
    chk("t4_cell4", int'(cell_state[9:8]), 2);
    chk("t4_conf", int'(wr_conflict), 1);
    chk("t4_occ", int'(occ_count), 1);
    pl_en = 9'h010; step(); pl_en = '0;
    chk("t4_cell4_kept", int'(cell_state[9:8]), 2);
    chk("t4_conf2", int'(wr_conflict), 1);
    chk("t4_occ2", int'(occ_count), 1);
    step();
    chk("t4_conf_drop", int'(wr_conflict), 0);

    // clear during SCAN on a full board
    pl_en = 9'h1EF; step(); pl_en = '0;
    req = 1; step(); req = 0;
    step();
    clear = 1; pl_en = 9'h001; step(); clear = 0; pl_en = '0;
    chk("t5_scan_busy", int'(busy), 0);
    chk("t5_scan_valid", int'(resp_valid), 0);
    chk("t5_scan_cells", int'(cell_state), 0);
    chk("t5_scan_occ", int'(occ_count), 0);

    // clear during RESP with resp_ready low
    req = 1; step(); req = 0;
    step();
    chk("t5_resp_valid", int'(resp_valid), 1);
    clear = 1; step(); clear = 0;
    chk("t5_resp_valid_drop", int'(resp_valid), 0);
    chk("t5_resp_busy", int'(busy), 0);

    // response held for 5 cycles with req pulses ignored
    pl_en = 9'h0AA; step(); pl_en = '0;
    req = 1; step();
    while (!resp_valid && m_mode == 1) step();
    held_pos = int'(resp_pos);
    for (int i = 0; i < 5; i++) begin
      req = i[0];
      step();
      chk("t6_valid_hold", int'(resp_valid), 1);
      chk("t6_pos_hold", int'(resp_pos), held_pos);
      chk("t6_rfull_hold", int'(resp_full), 0);
    end
    req = 1; resp_ready = 1; step(); resp_ready = 0; req = 0;
    chk("t6_hs_busy", int'(busy), 0);
    step();
    chk("t6_req_ignored", int'(busy), 0);

    // randomized traffic, checked by the per-cycle compare
    for (int n = 0; n < 3000; n++) begin
      pl_en = ($urandom_range(0, 3) == 0) ? (one << $urandom_range(0, CELLS - 1)) : '0;
      pc_en = ($urandom_range(0, 3) == 0) ? (one << $urandom_range(0, CELLS - 1)) : '0;
      if ($urandom_range(0, 19) == 0) pl_en = CELLS'($urandom) & CELLS'($urandom);
      req = ($urandom_range(0, 3) == 0);
      resp_ready = ($urandom_range(0, 2) != 0);
      clear = ($urandom_range(0, 39) == 0);
      reset = ($urandom_range(0, 499) == 0);
      step();
    end
    idle_inputs(); reset = 0;
    step(); step();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
